// File: rtl/fft_seq_param.sv
// Job sequencer for an in-place radix-2 DIT FFT: bit-reversed streaming load,
// LOG2N butterfly stages on a dual-port memory, then natural-order unload.
module fft_seq_param #(
  parameter int LOG2N   = 11,
  parameter int MEM_LAT = 1,
  parameter int BF_LAT  = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             inverse,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [LOG2N-1:0] mem_a_addr,
  output logic             mem_a_we,
  output logic             mem_a_src,
  output logic [LOG2N-1:0] mem_b_addr,
  output logic             mem_b_we,
  output logic [LOG2N-2:0] tf_addr,
  output logic             tf_conj,
  output logic             bf_enable,
  output logic             out_valid,
  output logic [LOG2N-1:0] out_index,
  output logic             busy,
  output logic             done
);

  localparam int N  = 1 << LOG2N;
  localparam int P  = MEM_LAT + BF_LAT + 1;
  localparam int SW = $clog2(LOG2N + 1);
  localparam int PW = $clog2(P + 1);
  localparam int HW = LOG2N - 1;
  localparam int IW = LOG2N + 2;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, UNLOAD} state_t;

  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] v);
    for (int b = 0; b < LOG2N; b++) bitrev[b] = v[LOG2N-1-b];
  endfunction

  state_t          state_q, state_d;
  logic [IW-1:0]   cnt_q, cnt_d;       // sample k in LOAD, read address i in UNLOAD
  logic [SW-1:0]   stage_q, stage_d;
  logic [HW-1:0]   bfly_q, bfly_d;
  logic [PW-1:0]   phase_q, phase_d;
  logic            inv_q, inv_d;

  logic [LOG2N-1:0] a_addr_q, a_addr_d, b_addr_q, b_addr_d;
  logic             a_we_q, a_we_d, a_src_q, a_src_d, b_we_q, b_we_d;
  logic [HW-1:0]    tf_q, tf_d;
  logic             bf_en_q, bf_en_d, conj_q, conj_d;
  logic             ready_q, ready_d, busy_q, busy_d;
  logic             issue_q, issue_d, last_q, last_d;

  logic [MEM_LAT-1:0] vld_pipe_q, last_pipe_q;
  logic [LOG2N-1:0]   idx_pipe_q [MEM_LAT];

  logic [LOG2N-1:0] half, mask, jx, addr0;

  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    state_d  = state_q;
    cnt_d    = cnt_q;
    stage_d  = stage_q;
    bfly_d   = bfly_q;
    phase_d  = phase_q;
    inv_d    = inv_q;
    a_addr_d = '0;
    b_addr_d = '0;
    a_we_d   = 1'b0;
    a_src_d  = 1'b0;
    b_we_d   = 1'b0;
    tf_d     = '0;
    bf_en_d  = 1'b0;
    issue_d  = 1'b0;
    last_d   = 1'b0;

    half  = LOG2N'(1) << stage_q;
    mask  = half - LOG2N'(1);
    jx    = {1'b0, bfly_q};
    addr0 = ((jx >> stage_q) << (stage_q + SW'(1))) | (jx & mask);

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD;
          inv_d   = inverse;
          cnt_d   = '0;
        end
      end
      LOAD: begin
        if (in_valid) begin
          a_we_d   = 1'b1;
          a_src_d  = 1'b1;
          a_addr_d = bitrev(cnt_q[LOG2N-1:0]);
          if (cnt_q == IW'(N - 1)) begin
            state_d = RUN;
            cnt_d   = '0;
            stage_d = '0;
            bfly_d  = '0;
            phase_d = '0;
          end else begin
            cnt_d = cnt_q + IW'(1);
          end
        end
      end
      RUN: begin
        // Addresses and twiddle index stay stable across all P phases of a butterfly.
        a_addr_d = addr0;
        b_addr_d = addr0 + half;
        tf_d     = HW'((jx & mask) << (SW'(LOG2N - 1) - stage_q));
        bf_en_d  = (phase_q >= PW'(MEM_LAT)) && (phase_q < PW'(MEM_LAT + BF_LAT));
        if (phase_q == PW'(P - 1)) begin
          a_we_d  = 1'b1;
          b_we_d  = 1'b1;
          phase_d = '0;
          bfly_d  = bfly_q + HW'(1);
          if (&bfly_q) begin
            stage_d = stage_q + SW'(1);
            if (stage_q == SW'(LOG2N - 1)) begin
              state_d = UNLOAD;
              cnt_d   = '0;
            end
          end
        end else begin
          phase_d = phase_q + PW'(1);
        end
      end
      UNLOAD: begin
        if (cnt_q < IW'(N)) begin
          issue_d  = 1'b1;
          a_addr_d = cnt_q[LOG2N-1:0];
          last_d   = (cnt_q == IW'(N - 1));
        end
        // Stay busy until the read pipeline has delivered the final bin.
        if (cnt_q == IW'(N + MEM_LAT)) state_d = IDLE;
        else                           cnt_d   = cnt_q + IW'(1);
      end
      default: state_d = IDLE;
    endcase

    ready_d = (state_d == LOAD);
    busy_d  = (state_d != IDLE);
    conj_d  = busy_d & inv_d;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      stage_q  <= '0;
      bfly_q   <= '0;
      phase_q  <= '0;
      inv_q    <= 1'b0;
      a_addr_q <= '0;
      b_addr_q <= '0;
      a_we_q   <= 1'b0;
      a_src_q  <= 1'b0;
      b_we_q   <= 1'b0;
      tf_q     <= '0;
      bf_en_q  <= 1'b0;
      conj_q   <= 1'b0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
      issue_q  <= 1'b0;
      last_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      stage_q  <= stage_d;
      bfly_q   <= bfly_d;
      phase_q  <= phase_d;
      inv_q    <= inv_d;
      a_addr_q <= a_addr_d;
      b_addr_q <= b_addr_d;
      a_we_q   <= a_we_d;
      a_src_q  <= a_src_d;
      b_we_q   <= b_we_d;
      tf_q     <= tf_d;
      bf_en_q  <= bf_en_d;
      conj_q   <= conj_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      issue_q  <= issue_d;
      last_q   <= last_d;
    end
  end

  // Result tagging trails the unload read address by the memory latency.
  always_ff @(posedge clock) begin
    // NOTE: this small pipeline is reset so an aborted job can never emit a stale done.
    if (reset) begin
      vld_pipe_q  <= '0;
      last_pipe_q <= '0;
      for (int i = 0; i < MEM_LAT; i++) idx_pipe_q[i] <= '0;
    end else begin
      vld_pipe_q[0]  <= issue_q;
      last_pipe_q[0] <= last_q;
      idx_pipe_q[0]  <= issue_q ? a_addr_q : '0;
      for (int i = 1; i < MEM_LAT; i++) begin
        vld_pipe_q[i]  <= vld_pipe_q[i-1];
        last_pipe_q[i] <= last_pipe_q[i-1];
        idx_pipe_q[i]  <= idx_pipe_q[i-1];
      end
    end
  end

  assign in_ready   = ready_q;
  assign mem_a_addr = a_addr_q;
  assign mem_a_we   = a_we_q;
  assign mem_a_src  = a_src_q;
  assign mem_b_addr = b_addr_q;
  assign mem_b_we   = b_we_q;
  assign tf_addr    = tf_q;
  assign tf_conj    = conj_q;
  assign bf_enable  = bf_en_q;
  assign busy       = busy_q;
  assign out_valid  = vld_pipe_q[MEM_LAT-1];
  assign out_index  = idx_pipe_q[MEM_LAT-1];
  assign done       = last_pipe_q[MEM_LAT-1];

endmodule

// File: tb/tb_fft_seq_param.sv
// Scoreboard bench for fft_seq_param (N=8): a small memory/butterfly model with
// unit twiddle, exact for the impulse jobs whose output bins are checked.
module tb_fft_seq_param;

  localparam int LN  = 3;
  localparam int ML  = 1;
  localparam int BL  = 2;
  localparam int N   = 1 << LN;
  localparam int P   = ML + BL + 1;
  localparam int NBF = LN * N / 2;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          inverse = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready, mem_a_we, mem_a_src, mem_b_we, tf_conj, bf_enable;
  logic          out_valid, busy, done;
  logic [LN-1:0] mem_a_addr, mem_b_addr, out_index;
  logic [LN-2:0] tf_addr;

  fft_seq_param #(.LOG2N(LN), .MEM_LAT(ML), .BF_LAT(BL)) dut (
    .clock(clock), .reset(reset), .start(start), .inverse(inverse),
    .in_valid(in_valid), .in_ready(in_ready),
    .mem_a_addr(mem_a_addr), .mem_a_we(mem_a_we), .mem_a_src(mem_a_src),
    .mem_b_addr(mem_b_addr), .mem_b_we(mem_b_we),
    .tf_addr(tf_addr), .tf_conj(tf_conj), .bf_enable(bf_enable),
    .out_valid(out_valid), .out_index(out_index), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  typedef struct {int a0; int a1; int tf;} bfly_t;

  int    brev [N] = '{0, 4, 2, 6, 1, 5, 3, 7};
  int    load_q[$], data_q[$], idx_q[$];
  bfly_t bf_q[$];
  int    mem [N];
  int    ah [ML], bh [ML];
  int    n_total = 0, n_bad = 0;
  int    cyc = 0, n_load = 0, n_wr = 0, bf_cnt = 0;
  int    last_load_cyc = 0, last_wr_cyc = 0, last_out_cyc = 0;
  int    rd_a, rd_b, a_lat, b_lat;
  bit    mon_on = 0, exp_conj = 0, chk_data = 0, job_done = 0, after_done = 0, bf_prev = 0;

  task automatic check(string tag, int got, int exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_idle(string tag);
    check({tag, "_ctrl"}, int'({in_ready, busy, done, out_valid, mem_a_we, mem_b_we,
                                mem_a_src, bf_enable, tf_conj}), 0);
    check({tag, "_addr"}, int'({mem_a_addr, mem_b_addr, tf_addr, out_index}), 0);
  endtask

  // Monitor: all DUT outputs are sampled on the falling edge.
  always @(negedge clock) begin
    if (mon_on) begin
      cyc++;
      rd_a = mem[ah[ML-1]];
      rd_b = mem[bh[ML-1]];
      for (int i = ML - 1; i > 0; i--) begin
        ah[i] = ah[i-1];
        bh[i] = bh[i-1];
      end
      ah[0] = int'(mem_a_addr);
      bh[0] = int'(mem_b_addr);

      if (busy) check("tf_conj", int'(tf_conj), int'(exp_conj));
      if (after_done) begin
        check("busy_after_done", int'(busy), 0);
        after_done = 0;
      end

      if (n_load == N && n_wr < NBF) begin
        check("run_busy", int'({busy, in_ready}), 2);
        if (bf_q.size() == 0) begin
          check("bf_q_empty", 1, 0);
        end else begin
          check("run_addr_a", int'(mem_a_addr), bf_q[0].a0);
          check("run_addr_b", int'(mem_b_addr), bf_q[0].a1);
          check("run_tf", int'(tf_addr), bf_q[0].tf);
          if (bf_enable) begin
            bf_cnt++;
            if (!bf_prev) begin
              a_lat = rd_a;
              b_lat = rd_b;
            end
          end
          if (mem_a_we) begin
            check("run_we_b", int'(mem_b_we), 1);
            check("run_src", int'(mem_a_src), 0);
            check("run_bf_cycles", bf_cnt, BL);
            check("run_spacing", cyc - (n_wr == 0 ? last_load_cyc : last_wr_cyc), P);
            mem[mem_a_addr] = a_lat + b_lat;
            mem[mem_b_addr] = a_lat - b_lat;
            void'(bf_q.pop_front());
            n_wr++;
            last_wr_cyc = cyc;
            bf_cnt = 0;
            if (n_wr == NBF) check("run_length", cyc - last_load_cyc, NBF * P);
          end else begin
            check("run_we_b_idle", int'(mem_b_we), 0);
          end
        end
      end else if (mem_a_we) begin
        check("load_src", int'(mem_a_src), 1);
        check("load_we_b", int'(mem_b_we), 0);
        if (load_q.size() == 0 || data_q.size() == 0) begin
          check("load_unexpected", 1, 0);
        end else begin
          check("load_addr", int'(mem_a_addr), load_q.pop_front());
          mem[mem_a_addr] = data_q.pop_front();
        end
        n_load++;
        last_load_cyc = cyc;
      end

      if (out_valid) begin
        if (idx_q.size() == 0) begin
          check("out_unexpected", 1, 0);
        end else begin
          int e;
          e = idx_q.pop_front();
          check("out_index", int'(out_index), e);
          check("done_with_last", int'(done), int'(e == N - 1));
          if (e == 0) check("unload_latency", cyc - last_wr_cyc, 1 + ML);
          else        check("out_consecutive", cyc - last_out_cyc, 1);
          if (chk_data) check("bin_value", rd_a, 1);
          last_out_cyc = cyc;
          if (done) begin
            job_done   = 1;
            after_done = 1;
          end
        end
      end else begin
        check("done_spurious", int'(done), 0);
      end
      bf_prev = bf_enable;
    end
  end

  task automatic start_job(bit inv, bit data_chk);
    load_q.delete();
    data_q.delete();
    idx_q.delete();
    bf_q.delete();
    n_load = 0; n_wr = 0; bf_cnt = 0; bf_prev = 0;
    job_done = 0; after_done = 0;
    exp_conj = inv;
    chk_data = data_chk;
    // Expected butterflies enumerated group by group rather than by index arithmetic.
    for (int s = 0; s < LN; s++) begin
      int h;
      h = 1 << s;
      for (int g = 0; g < N; g += 2 * h)
        for (int k = 0; k < h; k++)
          bf_q.push_back('{g + k, g + k + h, k * (N / (2 * h))});
    end
    for (int i = 0; i < N; i++) idx_q.push_back(i);
    mon_on = 1;
    @(negedge clock);
    start = 1'b1;
    inverse = inv;
    @(negedge clock);
    start = 1'b0;
    inverse = 1'b0;
    check("busy_on_start", int'(busy), 1);
  endtask

  task automatic feed(bit toggle, bit impulse);
    int k;
    bit gap;
    k = 0;
    gap = 0;
    for (int it = 0; it < 2 * N && k < N; it++) begin
      check("in_ready_load", int'(in_ready), 1);
      if (toggle && gap) begin
        in_valid = 1'b0;
      end else begin
        in_valid = 1'b1;
        load_q.push_back(brev[k]);
        data_q.push_back(impulse ? int'(k == 0) : int'($urandom_range(0, 9)));
        k++;
      end
      gap = !gap;
      @(negedge clock);
    end
    in_valid = 1'b0;
    check("in_ready_after_load", int'(in_ready), 0);
  endtask

  task automatic wait_done(string tag);
    for (int t = 0; t < 400 && !job_done; t++) @(negedge clock);
    check({tag, "_done_seen"}, int'(job_done), 1);
    @(negedge clock);
    @(negedge clock);
    check({tag, "_bf_left"}, bf_q.size(), 0);
    check({tag, "_idx_left"}, idx_q.size(), 0);
    check_idle({tag, "_idle"});
  endtask

  initial begin
    for (int i = 0; i < N; i++) mem[i] = 0;
    for (int i = 0; i < ML; i++) begin
      ah[i] = 0;
      bh[i] = 0;
    end
    repeat (3) @(negedge clock);
    check_idle("reset_state");
    reset = 1'b0;
    @(negedge clock);
    check_idle("post_reset");

    // Job 1: forward, impulse, continuous load.
    start_job(1'b0, 1'b1);
    feed(1'b0, 1'b1);
    wait_done("job1");

    // Job 2: inverse, gapped load, stray start during RUN.
    start_job(1'b1, 1'b0);
    feed(1'b1, 1'b0);
    repeat (6) @(negedge clock);
    start = 1'b1;
    inverse = 1'b0;
    @(negedge clock);
    start = 1'b0;
    check("busy_stray_start", int'(busy), 1);
    wait_done("job2");

    // Job 3: aborted by reset inside stage 1.
    start_job(1'b0, 1'b0);
    feed(1'b0, 1'b0);
    for (int t = 0; t < 200 && n_wr < NBF / LN + 1; t++) @(negedge clock);
    check("abort_in_stage1", int'(n_wr > NBF / LN && n_wr < 2 * NBF / LN), 1);
    mon_on = 0;
    reset = 1'b1;
    @(negedge clock);
    check_idle("abort_reset");
    reset = 1'b0;
    for (int t = 0; t < 4; t++) begin
      @(negedge clock);
      check("abort_no_done", int'({done, busy}), 0);
    end

    // Job 4: full forward job after the abort.
    start_job(1'b0, 1'b1);
    feed(1'b0, 1'b1);
    wait_done("job4");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
